// File: rtl/ar_ordering_unit_if.sv
// AR channel bundle: address-read request payload plus valid/ready handshake.
interface ar_if #(
    parameter int unsigned ID_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned LEN_WIDTH   = 8,
    parameter int unsigned SIZE_WIDTH  = 3,
    parameter int unsigned BURST_WIDTH = 2,
    parameter int unsigned QOS_WIDTH   = 4
);
    logic                   valid;
    logic                   ready;
    logic [ID_WIDTH-1:0]    id;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [LEN_WIDTH-1:0]   len;
    logic [SIZE_WIDTH-1:0]  size;
    logic [BURST_WIDTH-1:0] burst;
    logic [QOS_WIDTH-1:0]   qos;

    modport sender (
        output valid, id, addr, len, size, burst, qos,
        input  ready
    );

    modport receiver (
        input  valid, id, addr, len, size, burst, qos,
        output ready
    );
endinterface

// File: rtl/ar_ordering_unit.sv
// AR tag allocator: swaps master IDs for free internal tags, tracks per-ID order
// for the reorder buffer, and frees tags on ROB release.
module ar_ordering_unit #(
    parameter int unsigned ID_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned LEN_WIDTH   = 8,
    parameter int unsigned SIZE_WIDTH  = 3,
    parameter int unsigned BURST_WIDTH = 2,
    parameter int unsigned QOS_WIDTH   = 4,
    parameter int unsigned NUM_TAGS    = 16,
    localparam int unsigned TAG_W      = $clog2(NUM_TAGS),
    localparam int unsigned CNT_W      = $clog2(NUM_TAGS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    ar_if.receiver           ar_in,
    ar_if.sender             ar_out,
    output logic             alloc_valid,
    output logic [TAG_W-1:0] alloc_tag,
    output logic [ID_WIDTH-1:0]  alloc_orig_id,
    output logic [LEN_WIDTH-1:0] alloc_len,
    output logic [CNT_W-1:0] alloc_order_idx,
    input  logic             rel_valid,
    input  logic [TAG_W-1:0] rel_tag,
    output logic [CNT_W-1:0] outstanding,
    output logic             err_rel
);

    logic [NUM_TAGS-1:0]    valid_q;
    logic [ID_WIDTH-1:0]    orig_id_q [NUM_TAGS];
    logic [LEN_WIDTH-1:0]   len_q     [NUM_TAGS];

    logic                   out_valid_q;
    logic [ID_WIDTH-1:0]    out_id_q;
    logic [ADDR_WIDTH-1:0]  out_addr_q;
    logic [LEN_WIDTH-1:0]   out_len_q;
    logic [SIZE_WIDTH-1:0]  out_size_q;
    logic [BURST_WIDTH-1:0] out_burst_q;
    logic [QOS_WIDTH-1:0]   out_qos_q;

    logic                   any_free;
    logic [TAG_W-1:0]       free_tag;
    logic                   in_ready;
    logic                   accept;
    logic                   rel_in_range;
    logic                   rel_hit;
    logic                   rel_miss;
    logic [CNT_W-1:0]       order_cnt;

    // Lowest-index free tag from registered state, so a tag freed this cycle is not reused yet.
    always_comb begin
        free_tag = '0;
        for (int i = int'(NUM_TAGS) - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_tag = TAG_W'(i);
        end
    end

    assign any_free     = |(~valid_q);
    assign in_ready     = any_free & (~out_valid_q | ar_out.ready);
    assign accept       = ar_in.valid & in_ready;
    assign rel_in_range = (32'(rel_tag) < NUM_TAGS);
    assign rel_hit      = rel_valid & rel_in_range & valid_q[rel_tag];
    assign rel_miss     = rel_valid & ~rel_hit;

    // Older same-ID requests still live after this cycle's release.
    always_comb begin
        order_cnt = '0;
        for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            if (valid_q[i] && (orig_id_q[i] == ar_in.id) && !(rel_hit && (32'(rel_tag) == i)))
                order_cnt = order_cnt + CNT_W'(1);
        end
    end

    assign ar_in.ready  = in_ready;
    assign ar_out.valid = out_valid_q;
    assign ar_out.id    = out_id_q;
    assign ar_out.addr  = out_addr_q;
    assign ar_out.len   = out_len_q;
    assign ar_out.size  = out_size_q;
    assign ar_out.burst = out_burst_q;
    assign ar_out.qos   = out_qos_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            if (rel_hit) valid_q[rel_tag]  <= 1'b0;
            if (accept)  valid_q[free_tag] <= 1'b1;
        end
    end

    // Payload entries are only meaningful while their valid bit is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            orig_id_q[free_tag] <= ar_in.id;
            len_q[free_tag]     <= ar_in.len;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_addr_q  <= '0;
            out_len_q   <= '0;
            out_size_q  <= '0;
            out_burst_q <= '0;
            out_qos_q   <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_id_q    <= ID_WIDTH'(free_tag);
            out_addr_q  <= ar_in.addr;
            out_len_q   <= ar_in.len;
            out_size_q  <= ar_in.size;
            out_burst_q <= ar_in.burst;
            out_qos_q   <= ar_in.qos;
        end else if (ar_out.ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_valid     <= 1'b0;
            alloc_tag       <= '0;
            alloc_orig_id   <= '0;
            alloc_len       <= '0;
            alloc_order_idx <= '0;
        end else begin
            alloc_valid <= accept;
            if (accept) begin
                alloc_tag       <= free_tag;
                alloc_orig_id   <= ar_in.id;
                alloc_len       <= ar_in.len;
                alloc_order_idx <= order_cnt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            err_rel     <= 1'b0;
        end else begin
            case ({accept, rel_hit})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
            if (rel_miss) err_rel <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ar_ordering_unit.sv
// Bench for ar_ordering_unit: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ar_ordering_unit;

    localparam int unsigned NT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rel_valid;
    logic [3:0] rel_tag;
    logic       alloc_valid;
    logic [3:0] alloc_tag;
    logic [7:0] alloc_orig_id;
    logic [7:0] alloc_len;
    logic [4:0] alloc_order_idx;
    logic [4:0] outstanding;
    logic       err_rel;

    int n_tests = 0;
    int n_fail  = 0;

    ar_if in_bus ();
    ar_if out_bus ();

    ar_ordering_unit dut (
        .clk             (clk),
        .rst             (rst),
        .ar_in           (in_bus),
        .ar_out          (out_bus),
        .alloc_valid     (alloc_valid),
        .alloc_tag       (alloc_tag),
        .alloc_orig_id   (alloc_orig_id),
        .alloc_len       (alloc_len),
        .alloc_order_idx (alloc_order_idx),
        .rel_valid       (rel_valid),
        .rel_tag         (rel_tag),
        .outstanding     (outstanding),
        .err_rel         (err_rel)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int         tag;
        logic [7:0] id;
        logic [7:0] len;
    } ent_t;

    ent_t        live[$];
    logic        e_ov, e_av, e_err;
    logic [7:0]  e_id, e_len, e_aid, e_alen;
    logic [31:0] e_addr;
    logic [2:0]  e_size;
    logic [1:0]  e_burst;
    logic [3:0]  e_qos;
    int          e_atag, e_aord;

    function automatic bit tag_live(input int t);
        foreach (live[k]) if (live[k].tag == t) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            live.delete();
            e_ov = 0; e_av = 0; e_err = 0;
            e_id = 0; e_len = 0; e_addr = 0; e_size = 0; e_burst = 0; e_qos = 0;
            e_atag = 0; e_aord = 0; e_aid = 0; e_alen = 0;
            chk("rst_out_valid", out_bus.valid, 1'b0);
            chk("rst_out_addr", out_bus.addr, 32'h0);
            chk("rst_out_id", out_bus.id, 8'h0);
            chk("rst_alloc_valid", alloc_valid, 1'b0);
            chk("rst_alloc_tag", alloc_tag, 4'h0);
            chk("rst_outstanding", outstanding, 5'd0);
            chk("rst_err_rel", err_rel, 1'b0);
        end else begin
            bit acc, e_ready, found;
            int ftag, ridx, oidx;
            chk("out_valid", out_bus.valid, e_ov);
            if (e_ov) begin
                chk("out_id", out_bus.id, e_id);
                chk("out_addr", out_bus.addr, e_addr);
                chk("out_len", out_bus.len, e_len);
                chk("out_size", out_bus.size, e_size);
                chk("out_burst", out_bus.burst, e_burst);
                chk("out_qos", out_bus.qos, e_qos);
            end
            chk("alloc_valid", alloc_valid, e_av);
            if (e_av) begin
                chk("alloc_tag", alloc_tag, 64'(e_atag));
                chk("alloc_orig_id", alloc_orig_id, e_aid);
                chk("alloc_len", alloc_len, e_alen);
                chk("alloc_order_idx", alloc_order_idx, 64'(e_aord));
            end
            chk("outstanding", outstanding, 64'(live.size()));
            chk("err_rel", err_rel, e_err);

            // What the coming edge must do, given the inputs now applied
            e_ready = (live.size() < NT) && (!e_ov || out_bus.ready);
            chk("in_ready", in_bus.ready, e_ready);
            acc = in_bus.valid && e_ready;

            found = 0; ftag = 0;
            for (int t = 0; t < int'(NT); t++)
                if (!found && !tag_live(t)) begin found = 1; ftag = t; end

            ridx = -1;
            if (rel_valid)
                foreach (live[k]) if (live[k].tag == int'(rel_tag)) ridx = k;

            oidx = 0;
            foreach (live[k]) if (live[k].id == in_bus.id && k != ridx) oidx++;

            if (rel_valid) begin
                if (ridx >= 0) live.delete(ridx);
                else e_err = 1;
            end

            if (acc) begin
                live.push_back('{ftag, in_bus.id, in_bus.len});
                e_ov = 1; e_id = 8'(ftag); e_addr = in_bus.addr; e_len = in_bus.len;
                e_size = in_bus.size; e_burst = in_bus.burst; e_qos = in_bus.qos;
                e_av = 1; e_atag = ftag; e_aid = in_bus.id; e_alen = in_bus.len; e_aord = oidx;
            end else begin
                e_av = 0;
                if (out_bus.ready) e_ov = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive_req(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
        in_bus.id    = id;
        in_bus.addr  = addr;
        in_bus.len   = len;
        in_bus.size  = 3'd2;
        in_bus.burst = 2'b01;
        in_bus.qos   = 4'(id);
        in_bus.valid = 1'b1;
    endtask

    task automatic send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
        bit done = 0;
        drive_req(id, addr, len);
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            done = in_bus.ready;
            step();
        end
        in_bus.valid = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: id 0x%0h not accepted within 50 cycles", id);
        end
    endtask

    task automatic release_tag(input int t);
        rel_valid = 1'b1;
        rel_tag   = 4'(t);
        step();
        rel_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rel_valid = 1'b0;
        rel_tag = '0;
        in_bus.valid = 1'b0;
        in_bus.id = '0; in_bus.addr = '0; in_bus.len = '0;
        in_bus.size = '0; in_bus.burst = '0; in_bus.qos = '0;
        out_bus.ready = 1'b1;
        repeat (2) step();
        chk("lit_reset_outstanding", outstanding, 5'd0);
        chk("lit_reset_out_valid", out_bus.valid, 1'b0);
        rst = 1'b0;
        step();

        // Single request
        send(8'h5A, 32'h1000, 8'd3);
        chk("lit_single_out_id", out_bus.id, 8'h00);
        chk("lit_single_out_addr", out_bus.addr, 32'h1000);
        chk("lit_single_out_len", out_bus.len, 8'd3);
        chk("lit_single_alloc_tag", alloc_tag, 4'd0);
        chk("lit_single_orig_id", alloc_orig_id, 8'h5A);
        chk("lit_single_order", alloc_order_idx, 5'd0);
        chk("lit_single_outstanding", outstanding, 5'd1);
        step();
        release_tag(0);

        // Back-to-back same ID, then a different ID
        for (int i = 0; i < 3; i++) begin
            send(8'h07, 32'h100 * (i + 1), 8'(i));
            chk("lit_b2b_tag", alloc_tag, 4'(i));
            chk("lit_b2b_order", alloc_order_idx, 5'(i));
        end
        send(8'h08, 32'h4000, 8'd1);
        chk("lit_other_id_tag", alloc_tag, 4'd3);
        chk("lit_other_id_order", alloc_order_idx, 5'd0);
        for (int t = 0; t < 4; t++) release_tag(t);

        // Fill every tag, then free one
        for (int i = 0; i < int'(NT); i++) send(8'(8'h10 + i), 32'h8000 + 32'(i * 64), 8'd0);
        chk("lit_full_outstanding", outstanding, 5'd16);
        chk("lit_full_ready", in_bus.ready, 1'b0);
        step();
        chk("lit_full_ready_idle", in_bus.ready, 1'b0);
        release_tag(5);
        chk("lit_after_rel_ready", in_bus.ready, 1'b1);
        chk("lit_after_rel_outstanding", outstanding, 5'd15);
        send(8'h99, 32'h9000, 8'd2);
        chk("lit_reuse_tag", alloc_tag, 4'd5);

        // Release and request in the same cycle while full
        drive_req(8'h77, 32'h7000, 8'd4);
        rel_valid = 1'b1;
        rel_tag   = 4'd2;
        @(negedge clk);
        chk("lit_same_cycle_no_accept", in_bus.ready, 1'b0);
        step();
        rel_valid = 1'b0;
        @(negedge clk);
        chk("lit_same_cycle_next_ready", in_bus.ready, 1'b1);
        step();
        in_bus.valid = 1'b0;
        chk("lit_same_cycle_tag", alloc_tag, 4'd2);
        chk("lit_same_cycle_outstanding", outstanding, 5'd16);
        for (int t = 0; t < 4; t++) release_tag(t);

        // Backpressure on the output slot
        out_bus.ready = 1'b0;
        send(8'h21, 32'h2000, 8'd5);
        drive_req(8'h22, 32'h3000, 8'd6);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("lit_bp_in_ready", in_bus.ready, 1'b0);
            chk("lit_bp_addr_stable", out_bus.addr, 32'h2000);
            chk("lit_bp_id_stable", out_bus.id, 8'h00);
            step();
        end
        out_bus.ready = 1'b1;
        @(negedge clk);
        chk("lit_bp_release_ready", in_bus.ready, 1'b1);
        step();
        in_bus.valid = 1'b0;
        chk("lit_bp_next_addr", out_bus.addr, 32'h3000);
        chk("lit_bp_next_tag", alloc_tag, 4'd1);

        // Error flag and mid-run reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) send(8'h33, 32'h5000 + 32'(i), 8'd1);
        rel_valid = 1'b1;
        rel_tag   = 4'd0;
        send(8'h33, 32'h5010, 8'd1);
        rel_valid = 1'b0;
        chk("lit_rel_accept_tag", alloc_tag, 4'd3);
        chk("lit_rel_accept_order", alloc_order_idx, 5'd2);
        release_tag(9);
        chk("lit_err_set", err_rel, 1'b1);
        chk("lit_err_outstanding", outstanding, 5'd3);
        repeat (3) step();
        chk("lit_err_sticky", err_rel, 1'b1);
        rst = 1'b1;
        #1;
        chk("lit_rst_outstanding", outstanding, 5'd0);
        chk("lit_rst_err", err_rel, 1'b0);
        chk("lit_rst_out_valid", out_bus.valid, 1'b0);
        step();
        rst = 1'b0;
        send(8'h44, 32'h6000, 8'd0);
        chk("lit_post_rst_tag", alloc_tag, 4'd0);
        chk("lit_post_rst_outstanding", outstanding, 5'd1);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
